// File: rtl/vector_bram_responder.sv
// rtl/vector_bram_responder.sv - arbitrated row bank: paired A/B row reads, masked row writes, 3-deep response FIFO
// Optional RSP_ZERO_INIT_EN: zero-fill sweep of every row after reset before serving traffic.
module vector_bram_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_ELEMENTS = 4,
    localparam int ROW_W       = DATA_WIDTH * NUM_ELEMENTS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req_valid,
    output logic                    rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
    output logic                    rd_resp_valid,
    input  logic                    rd_resp_ready,
    output logic [ROW_W-1:0]        rd_data_a,
    output logic [ROW_W-1:0]        rd_data_b,
    input  logic                    wr_req_valid,
    output logic                    wr_req_ready,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [ROW_W-1:0]        wr_data,
    input  logic [NUM_ELEMENTS-1:0] wr_mask,
    output logic                    wr_ack
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN} state_t;

`ifdef RSP_ZERO_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_addr;
    logic                  init_we;
    logic                  last_was_rd;
    logic [1:0]            credit_cnt;
    logic                  rd_pend;
    logic                  wr_pend;
    logic [ROW_W-1:0]      pend_a, pend_b;
    logic [ROW_W-1:0]      mem [DEPTH];
    logic [ROW_W-1:0]      fifo_a [3];
    logic [ROW_W-1:0]      fifo_b [3];
    logic [1:0]            head, tail, count;
    logic                  run, pop, rd_elig, grant_rd, grant_wr;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign run      = (state == ST_RUN);
    assign pop      = rd_resp_valid & rd_resp_ready;
    // Credits cover both the in-flight read and FIFO occupancy, so a pop frees a slot this cycle.
    assign rd_elig  = run & ((credit_cnt != 2'd3) | pop);
    assign grant_rd = rd_req_valid & rd_elig & (~wr_req_valid | ~last_was_rd);
    assign grant_wr = run & wr_req_valid & (~rd_req_valid | ~rd_elig | last_was_rd);

    assign rd_req_ready  = grant_rd;
    assign wr_req_ready  = grant_wr;
    assign rd_resp_valid = (count != 2'd0);
    assign rd_data_a     = rd_resp_valid ? fifo_a[head] : '0;
    assign rd_data_b     = rd_resp_valid ? fifo_b[head] : '0;

`ifdef RSP_ZERO_INIT_EN
    assign init_we = (state == ST_INIT);
`else
    assign init_we = 1'b0;
`endif

    // Storage and datapath registers carry no reset: memory must survive rst.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= '0;
        end else if (grant_wr) begin
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][i*DATA_WIDTH +: DATA_WIDTH] <= wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (grant_rd) begin
            pend_a <= mem[rd_addr_a];
            pend_b <= mem[rd_addr_b];
        end
        if (rd_pend) begin
            fifo_a[tail] <= pend_a;
            fifo_b[tail] <= pend_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RESET_STATE;
            init_addr   <= '0;
            last_was_rd <= 1'b0;
            credit_cnt  <= 2'd0;
            rd_pend     <= 1'b0;
            wr_pend     <= 1'b0;
            wr_ack      <= 1'b0;
            head        <= 2'd0;
            tail        <= 2'd0;
            count       <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_RUN;
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (&init_addr) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase

            rd_pend <= grant_rd;
            wr_pend <= grant_wr;
            wr_ack  <= wr_pend;

            if (grant_rd | grant_wr) begin
                last_was_rd <= grant_rd;
            end

            case ({grant_rd, pop})
                2'b10:   credit_cnt <= credit_cnt + 2'd1;
                2'b01:   credit_cnt <= credit_cnt - 2'd1;
                default: credit_cnt <= credit_cnt;
            endcase

            if (rd_pend) begin
                tail <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            case ({rd_pend, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_bram_responder.sv
// tb/tb_vector_bram_responder.sv - scoreboard bench for vector_bram_responder (default build)
module tb_vector_bram_responder;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NE = 4;
    localparam int RW = DW * NE;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd_req_valid = 1'b0;
    logic          rd_req_ready;
    logic [AW-1:0] rd_addr_a = '0;
    logic [AW-1:0] rd_addr_b = '0;
    logic          rd_resp_valid;
    logic          rd_resp_ready = 1'b1;
    logic [RW-1:0] rd_data_a, rd_data_b;
    logic          wr_req_valid = 1'b0;
    logic          wr_req_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [RW-1:0] wr_data = '0;
    logic [NE-1:0] wr_mask = '0;
    logic          wr_ack;

    vector_bram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ELEMENTS(NE)) dut (
        .clk(clk), .rst(rst),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wr_req_valid(wr_req_valid), .wr_req_ready(wr_req_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_ack(wr_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [RW-1:0]     ref_mem [int];
    logic [2*RW-1:0]   exp_q [$];
    int                ack_q [$];

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] rand_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference model: updates on handshakes seen just before the committing edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ack_q.delete();
        end else begin
            if (rd_req_valid && rd_req_ready) begin
                exp_q.push_back({ref_mem[int'(rd_addr_a)], ref_mem[int'(rd_addr_b)]});
            end
            if (wr_req_valid && wr_req_ready) begin
                logic [RW-1:0] row;
                row = ref_mem.exists(int'(wr_addr)) ? ref_mem[int'(wr_addr)] : '0;
                for (int i = 0; i < NE; i++) begin
                    if (wr_mask[i]) row[i*DW +: DW] = wr_data[i*DW +: DW];
                end
                ref_mem[int'(wr_addr)] = row;
                ack_q.push_back(cyc + 2);
            end
        end
    end

    // Monitor: pops responses/acks as the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_resp_valid && rd_resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rd_resp_unexpected", rd_resp_valid, 1'b0);
                end else begin
                    logic [2*RW-1:0] e;
                    e = exp_q.pop_front();
                    chk("rd_resp_a", rd_data_a, e[2*RW-1:RW]);
                    chk("rd_resp_b", rd_data_b, e[RW-1:0]);
                end
            end else if (!rd_resp_valid) begin
                chk("empty_data_zero", rd_data_a | rd_data_b, '0);
            end
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                chk("wr_ack", wr_ack, 1'b1);
                void'(ack_q.pop_front());
            end else begin
                chk("wr_ack_idle", wr_ack, 1'b0);
            end
            if (rd_req_ready && wr_req_ready) chk("both_ready", 1'b1, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [RW-1:0] d, input logic [NE-1:0] m);
        logic got = 1'b0;
        wr_req_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = wr_req_ready;
            tick();
        end
        wr_req_valid = 1'b0;
        chk("wr_accept", got, 1'b1);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic got = 1'b0;
        rd_req_valid = 1'b1; rd_addr_a = a; rd_addr_b = b;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = rd_req_ready;
            tick();
        end
        rd_req_valid = 1'b0;
        chk("rd_accept", got, 1'b1);
    endtask

    task automatic wait_drain();
        logic done = 1'b0;
        rd_resp_ready = 1'b1;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && !rd_resp_valid;
        end
        chk("drain", done, 1'b1);
        tick();
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [RW-1:0] exp_a);
        logic seen = 1'b0;
        wait_drain();
        do_read(a, b);
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = rd_resp_valid;
        end
        chk({name, "_valid"}, seen, 1'b1);
        chk(name, rd_data_a, exp_a);
        tick();
    endtask

    task automatic stream_reads(input int cycles, inout int n, input int limit);
        logic acc;
        rd_req_valid = (n < limit);
        rd_addr_a = AW'(n + 1); rd_addr_b = AW'(5 - n);
        for (int t = 0; t < cycles && n < limit; t++) begin
            @(negedge clk);
            acc = rd_req_ready;
            tick();
            if (acc) begin
                n++;
                rd_addr_a = AW'(n + 1); rd_addr_b = AW'(5 - n);
                rd_req_valid = (n < limit);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [RW-1:0] d1, d2;
        logic [3:0]    seq;
        logic          acc;
        int            n;
        d1 = 128'h0000000D_0000000C_0000000B_0000000A;
        d2 = 128'h0000000D_FFFFFFFF_0000000B_FFFFFFFF;

        // Reset state with both requests asserted
        rd_req_valid = 1'b1; wr_req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_rd_req_ready", rd_req_ready, 1'b0);
            chk("rst_wr_req_ready", wr_req_ready, 1'b0);
            chk("rst_rd_resp_valid", rd_resp_valid, 1'b0);
            chk("rst_rd_data", rd_data_a | rd_data_b, '0);
            chk("rst_wr_ack", wr_ack, 1'b0);
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        for (int r = 0; r < 16; r++) do_write(AW'(r), rand_row(), 4'hF);

        // Write then read-after-write with latency probe
        wait_drain();
        do_write(AW'(5), d1, 4'hF);
        rd_req_valid = 1'b1; rd_addr_a = AW'(5); rd_addr_b = AW'(5);
        @(negedge clk);
        chk("raw_rd_ready", rd_req_ready, 1'b1);
        tick();
        rd_req_valid = 1'b0;
        @(negedge clk);
        chk("raw_wr_ack", wr_ack, 1'b1);
        chk("raw_lat_early", rd_resp_valid, 1'b0);
        tick();
        @(negedge clk);
        chk("raw_lat_valid", rd_resp_valid, 1'b1);
        chk("raw_data_a", rd_data_a, d1);
        chk("raw_data_b", rd_data_b, d1);
        tick();

        do_write(AW'(5), {NE{32'hFFFFFFFF}}, 4'b0101);
        read_check("masked_write", AW'(5), AW'(5), d2);
        do_write(AW'(5), rand_row(), 4'b0000);
        read_check("mask_zero_write", AW'(5), AW'(7), d2);

        // Backpressure: only three reads may be outstanding
        wait_drain();
        rd_resp_ready = 1'b0;
        n = 0;
        stream_reads(8, n, 5);
        chk("bp_accepted", n, 3);
        @(negedge clk);
        chk("bp_rd_ready_low", rd_req_ready, 1'b0);
        tick();
        rd_resp_ready = 1'b1;
        stream_reads(20, n, 5);
        chk("bp_total", n, 5);
        rd_req_valid = 1'b0;

        // Contention right after reset: R, W, R, W
        wait_drain();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        seq = '0;
        rd_req_valid = 1'b1; wr_req_valid = 1'b1; wr_mask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            rd_addr_a = AW'(5); rd_addr_b = AW'(1 + k);
            wr_addr = AW'(20 + k); wr_data = rand_row();
            @(negedge clk);
            seq = {seq[2:0], rd_req_ready};
            chk("contend_one_grant", rd_req_ready ^ wr_req_ready, 1'b1);
            tick();
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        chk("contend_order", seq, 4'b1010);

        // Reset with two reads in flight, none popped
        wait_drain();
        rd_resp_ready = 1'b0;
        n = 0;
        rd_req_valid = 1'b1; rd_addr_a = AW'(2); rd_addr_b = AW'(3);
        for (int t = 0; t < 10 && n < 2; t++) begin
            @(negedge clk);
            acc = rd_req_ready;
            tick();
            if (acc) n++;
        end
        rst = 1'b1;
        rd_req_valid = 1'b0;
        chk("mid_reads_accepted", n, 2);
        @(negedge clk);
        chk("mid_rst_valid", rd_resp_valid, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", rd_resp_valid, 1'b0);
        chk("post_rst_data", rd_data_a | rd_data_b, '0);
        tick();
        n = 0;
        stream_reads(8, n, 5);
        chk("post_rst_credits", n, 3);
        rd_req_valid = 1'b0;
        wait_drain();
        read_check("mem_kept", AW'(5), AW'(5), d2);

        // Randomized mixed traffic over the pre-filled rows
        for (int t = 0; t < 400; t++) begin
            rd_req_valid  = ($urandom_range(0, 1) == 1);
            rd_addr_a     = AW'($urandom_range(0, 15));
            rd_addr_b     = AW'($urandom_range(0, 15));
            wr_req_valid  = ($urandom_range(0, 2) == 0);
            wr_addr       = AW'($urandom_range(0, 15));
            wr_data       = rand_row();
            wr_mask       = NE'($urandom_range(0, 15));
            rd_resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        wait_drain();
        repeat (3) tick();
        chk("final_resp_queue", exp_q.size(), 0);
        chk("final_ack_queue", ack_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vector_bram_responder.md
# vector_bram_responder

Memory-side responder for the SIMD datapath's row fetch/store traffic: holds 2**ADDR_WIDTH rows of NUM_ELEMENTS×DATA_WIDTH bits and serves paired A/B row reads plus masked R row writes over valid/ready handshakes. It sits behind the fetch/store path, replacing direct BRAM wiring with a flow-controlled, arbitrated, pipelined bank.

## Interface
- ADDR_WIDTH, 10, row address width; depth = 2**ADDR_WIDTH rows
- DATA_WIDTH, 32, element width
- NUM_ELEMENTS, 4, elements per row; ROW_W = DATA_WIDTH*NUM_ELEMENTS
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_req_valid  in  1  read request (A and B rows) present
- rd_req_ready  out  1  read request accepted when valid&ready at edge
- rd_addr_a, rd_addr_b  in  ADDR_WIDTH  row addresses
- rd_resp_valid  out  1  response at FIFO head
- rd_resp_ready  in  1  consumer pops response
- rd_data_a, rd_data_b  out  ROW_W  response rows, element 0 in LSBs
- wr_req_valid  in  1  write request present
- wr_req_ready  out  1  write accepted when valid&ready at edge
- wr_addr  in  ADDR_WIDTH  row address
- wr_data  in  ROW_W  row data
- wr_mask  in  NUM_ELEMENTS  per-element write enable, bit i covers element i
- wr_ack  out  1  one-cycle pulse, cycle after write commits

## Operation
- States: INIT (only with RSP_ZERO_INIT_EN) -> RUN. Without the macro, reset goes straight to RUN.
- One memory access per cycle: either a read (both A and B rows) or a write.
- Arbitration in RUN: only one valid -> it wins if eligible. Both valid and read eligible -> grant the side NOT granted last; last_grant updates on every grant. Reset value of last_grant = write, so first contention goes to read.
- Read eligibility: credit_cnt < 3, or a response pops this cycle (rd_resp_valid & rd_resp_ready). rd_req_ready = granted read; wr_req_ready = granted write. Both readies combinational from valids, arbiter state, credits.
- credit_cnt (0..3): +1 on read accept, −1 on pop, unchanged when both.
- Read pipeline: accept edge N registers memory outputs at N+1; pushes into 3-entry response FIFO at N+1; rd_resp_valid visible after edge N+1 if FIFO was empty. Responses strictly in request order.
- Write: elements with wr_mask[i]=1 overwritten at accept edge; others unchanged. wr_mask=0 still accepted and acked.
- Read-after-write: read accepted at edge ≥ write accept edge + 1 returns new data (accesses never share a cycle, so no same-cycle hazard).
- Same address for A and B is legal; both outputs equal.
- FIFO never overflows by credit construction; pop on empty impossible (rd_resp_valid=0).
- rd_data_a/b hold the FIFO head; zero when empty.

## Timing
- Reset values: rd_req_ready=0, wr_req_ready=0, rd_resp_valid=0, rd_data_a=rd_data_b=0, wr_ack=0, credit_cnt=0, FIFO empty.
- Read latency: accept edge N -> rd_resp_valid high in cycle after edge N+1 (1 cycle).
- Write latency: accept edge N -> wr_ack high for cycle after edge N+1 only.
- Throughput: 1 read/cycle with rd_resp_ready held high and no writes; 1 write/cycle with no reads; contention alternates R,W,R,W.
- Reset mid-operation: in-flight reads and FIFO contents discarded, credits cleared, pending wr_ack dropped; memory contents kept (re-cleared with RSP_ZERO_INIT_EN). A write accepted on the edge before reset is committed.

## Configuration
- RSP_ZERO_INIT_EN defined: after rst deassert, INIT sweeps rows 0..2**ADDR_WIDTH−1, writing zeros one row per cycle; both readies 0 throughout; RUN entered on edge after last row (2**ADDR_WIDTH cycles). Reads of never-written rows return 0.
- Undefined: no INIT; RUN on first edge after reset; unwritten row contents undefined (X in sim).

## Test plan
- Write addr 5, data {4'hA…}=128'h0000000D_0000000C_0000000B_0000000A, mask 4'b1111; read A=5,B=5 next cycle -> wr_ack one cycle, rd_data_a=rd_data_b=that value, 1 cycle after accept.
- Masked write addr 5 data all 32'hFFFFFFFF mask 4'b0101; read A=5 -> 128'h0000000D_FFFFFFFF_0000000B_FFFFFFFF.
- Backpressure: rd_resp_ready=0, stream reads to addrs 1..5 -> exactly 3 accepted, rd_req_ready low; release ready -> responses 1,2,3 in order, then 4,5 accepted.
- Contention: both valid 4 cycles -> grant order read, write, read, write; all data/acks correct.
- Reset mid-stream after 2 reads accepted, none popped -> rd_resp_valid=0, credit_cnt=0 next cycle; prior write at addr 5 still readable (macro off).
- RSP_ZERO_INIT_EN, ADDR_WIDTH=4: readies low 16 cycles after reset release; read addr 15 -> 0.
